// File: rtl/irq_catch.sv
// irq_catch: interrupt receiver with per-line polarity/strobe mode, glitch filter and W1C pending/overrun.
// Define IRQ_CATCH_SYNC_EN to pass every line through a 2-flop synchronizer first.
module irq_catch #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 srst_n_i,
    input  logic [N_IRQ-1:0]     irq_lines_i,
    input  logic [2*N_IRQ-1:0]   irq_mode_i,
    input  logic [15:0]          min_len_i,
    input  logic [N_IRQ-1:0]     enable_i,
    input  logic                 clear_i,
    input  logic [N_IRQ-1:0]     clear_mask_i,
    output logic [N_IRQ-1:0]     pending_o,
    output logic [N_IRQ-1:0]     overrun_o,
    output logic                 irq_o,
    output logic [ID_W-1:0]      irq_id_o
);
    logic [N_IRQ-1:0]   line_s;
    logic [N_IRQ-1:0]   idle_lvl;
    logic [2*N_IRQ-1:0] mode_q;
    logic [15:0]        cnt_q [N_IRQ];
    logic [15:0]        cnt_d [N_IRQ];
    logic [N_IRQ-1:0]   fired_q, fired_d;
    logic [N_IRQ-1:0]   pending_q, pending_d;
    logic [N_IRQ-1:0]   overrun_q, overrun_d;
    logic [N_IRQ-1:0]   masked;
    logic [15:0]        min_eff;

    assign min_eff = (min_len_i == 16'd0) ? 16'd1 : min_len_i;

    for (genvar i = 0; i < N_IRQ; i++) begin : g_idle
        assign idle_lvl[i] = irq_mode_i[2*i] ^ irq_mode_i[2*i+1];
    end

`ifdef IRQ_CATCH_SYNC_EN
    logic [N_IRQ-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            sync1_q <= idle_lvl;
            sync2_q <= idle_lvl;
        end else begin
            sync1_q <= irq_lines_i;
            sync2_q <= sync1_q;
        end
    end
    assign line_s = sync2_q;
`else
    assign line_s = irq_lines_i;
`endif

    for (genvar i = 0; i < N_IRQ; i++) begin : g_line
        logic        act, strobe, chg, run, qual, evt, clr;
        logic [16:0] cnt_inc;
        assign strobe  = irq_mode_i[2*i];
        assign act     = line_s[i] ^ idle_lvl[i];
        assign chg     = irq_mode_i[2*i +: 2] != mode_q[2*i +: 2];
        // a mode change restarts the filter and suppresses this cycle's event
        assign run     = act & ~chg;
        assign cnt_inc = {1'b0, cnt_q[i]} + 17'd1;
        assign qual    = run & (cnt_inc >= {1'b0, min_eff});
        assign evt     = qual & ~(strobe & fired_q[i]);
        assign clr     = clear_i & clear_mask_i[i];
        assign cnt_d[i]     = run ? (cnt_inc[16] ? 16'hFFFF : cnt_inc[15:0]) : 16'd0;
        assign fired_d[i]   = run & (fired_q[i] | evt);
        assign pending_d[i] = evt | (~clr & pending_q[i]);
        assign overrun_d[i] = ~clr & (overrun_q[i] | (evt & pending_q[i] & strobe));
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            mode_q    <= '0;
            cnt_q     <= '{default: '0};
            fired_q   <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            mode_q    <= irq_mode_i;
            cnt_q     <= cnt_d;
            fired_q   <= fired_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign masked    = pending_q & enable_i;
    assign pending_o = pending_q;
    assign overrun_o = overrun_q;
    assign irq_o     = |masked;

    always_comb begin
        irq_id_o = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (masked[i]) irq_id_o = ID_W'(i);
        end
    end
endmodule

// File: tb/tb_irq_catch.sv
// tb_irq_catch: scoreboard bench for irq_catch (default build), behavioural model plus directed checks.
module tb_irq_catch;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        srst_n;
    logic [7:0]  lines, enable, mask, pend, ovr;
    logic [15:0] mode, min_len;
    logic        clear, irq;
    logic [2:0]  id;

    always #5 clk = ~clk;

    irq_catch #(.N_IRQ(N)) dut (
        .clk_i(clk), .srst_n_i(srst_n), .irq_lines_i(lines), .irq_mode_i(mode),
        .min_len_i(min_len), .enable_i(enable), .clear_i(clear), .clear_mask_i(mask),
        .pending_o(pend), .overrun_o(ovr), .irq_o(irq), .irq_id_o(id)
    );

    typedef struct packed {
        logic [7:0] p;
        logic [7:0] o;
        logic       irq;
        logic [2:0] id;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         m_cnt[N];
    bit         m_fired[N];
    logic [1:0] m_mode[N];
    logic [7:0] m_pend = '0;
    logic [7:0] m_ovr = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // next-state of the receiver from the inputs currently driven
    task automatic model_push();
        logic [7:0] np, no;
        logic [1:0] m;
        bit         act, str, ev, clr;
        int         eff;
        exp_t       e;
        eff = (min_len == 16'd0) ? 1 : int'(min_len);
        for (int i = 0; i < N; i++) begin
            m   = mode[2*i +: 2];
            act = (m == 2'd0 || m == 2'd3) ? lines[i] : !lines[i];
            str = (m == 2'd1 || m == 2'd3);
            ev  = 0;
            if (m != m_mode[i] || !act) begin
                m_cnt[i] = 0;
                m_fired[i] = 0;
            end else begin
                ev = (m_cnt[i] + 1 >= eff) && !(str && m_fired[i]);
                if (m_cnt[i] < 65535) m_cnt[i]++;
                if (ev) m_fired[i] = 1;
            end
            m_mode[i] = m;
            clr   = clear && mask[i];
            np[i] = ev ? 1'b1 : clr ? 1'b0 : m_pend[i];
            no[i] = clr ? 1'b0 : (ev && m_pend[i] && str) ? 1'b1 : m_ovr[i];
            if (!srst_n) begin
                m_cnt[i] = 0;
                m_fired[i] = 0;
                m_mode[i] = 2'd0;
            end
        end
        if (!srst_n) begin
            np = '0;
            no = '0;
        end
        m_pend = np;
        m_ovr  = no;
        e.p    = np;
        e.o    = no;
        e.irq  = |(np & enable);
        e.id   = '0;
        for (int i = N - 1; i >= 0; i--) if (np[i] && enable[i]) e.id = 3'(i);
        sb.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("sb_pending", 32'(pend), 32'(e.p));
            check("sb_overrun", 32'(ovr), 32'(e.o));
            check("sb_irq", 32'(irq), 32'(e.irq));
            check("sb_id", 32'(id), 32'(e.id));
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        srst_n  = 1'b0;
        mode    = {2'd0, 2'd3, 2'd2, 2'd0, 2'd3, 2'd3, 2'd3, 2'd1};
        lines   = 8'h21;
        min_len = 16'd1;
        enable  = 8'hFF;
        clear   = 1'b0;
        mask    = 8'h00;
        cycles(2);
        check("reset_pending", 32'(pend), 32'h0);
        check("reset_overrun", 32'(ovr), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_id", 32'(id), 32'h0);
        srst_n = 1'b1;
        cycles(2);

        min_len = 16'd3;
        lines[2] = 1'b1;
        cycles(2);
        lines[2] = 1'b0;
        cycle();
        check("short_pulse_none", 32'(pend), 32'h0);
        lines[2] = 1'b1;
        cycles(2);
        check("before_third_edge", 32'(pend), 32'h0);
        cycle();
        check("after_third_edge", 32'(pend), 32'h04);
        check("strobe_irq", 32'(irq), 32'h1);
        check("strobe_id", 32'(id), 32'h2);
        cycles(2);
        lines[2] = 1'b0;
        cycle();
        check("one_event_pend", 32'(pend), 32'h04);
        check("one_event_ovr", 32'(ovr), 32'h0);
        clear = 1'b1; mask = 8'h04;
        cycle();
        clear = 1'b0;
        check("clear_line2", 32'(pend), 32'h0);

        min_len = 16'd1;
        lines[0] = 1'b0; cycle();
        check("strobe_n_pend", 32'(pend), 32'h01);
        lines[0] = 1'b1; cycle();
        lines[0] = 1'b0; cycle();
        lines[0] = 1'b1; cycle();
        check("overrun_set", 32'(ovr), 32'h01);
        clear = 1'b1; mask = 8'h01;
        cycle();
        clear = 1'b0;
        check("w1c_pend0", 32'(pend[0]), 32'h0);
        check("w1c_ovr0", 32'(ovr[0]), 32'h0);

        lines[5] = 1'b0; cycle();
        clear = 1'b1; mask = 8'h20;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("level_held_pend5", 32'(pend[5]), 32'h1);
            check("level_no_ovr5", 32'(ovr[5]), 32'h0);
        end
        clear = 1'b0;
        lines[5] = 1'b1; cycle();
        clear = 1'b1; cycle();
        clear = 1'b0;
        check("level_released_clear", 32'(pend[5]), 32'h0);

        lines[1] = 1'b1; cycle();
        lines[1] = 1'b0; cycle();
        lines[1] = 1'b1; clear = 1'b1; mask = 8'h02;
        cycle();
        clear = 1'b0;
        check("evt_beats_clear", 32'(pend[1]), 32'h1);
        check("clear_blocks_ovr", 32'(ovr[1]), 32'h0);
        lines[1] = 1'b0; clear = 1'b1; cycle();
        clear = 1'b0;

        lines[3] = 1'b1; lines[6] = 1'b1; cycle();
        lines[3] = 1'b0; lines[6] = 1'b0; cycle();
        check("two_pending", 32'(pend), 32'h48);
        enable = 8'hF7; cycle();
        check("masked_id", 32'(id), 32'h6);
        enable = 8'h00; cycle();
        check("all_masked_irq", 32'(irq), 32'h0);
        check("all_masked_pend", 32'(pend), 32'h48);

        enable = 8'hFF; min_len = 16'd4;
        lines[7] = 1'b1; cycles(2);
        srst_n = 1'b0; cycle();
        check("midreset_pend", 32'(pend), 32'h0);
        check("midreset_ovr", 32'(ovr), 32'h0);
        check("midreset_irq", 32'(irq), 32'h0);
        check("midreset_id", 32'(id), 32'h0);
        srst_n = 1'b1; cycles(3);
        check("requal_early", 32'(pend), 32'h0);
        cycle();
        check("requal_pend", 32'(pend), 32'h80);
        check("requal_id", 32'(id), 32'h7);

        for (int k = 0; k < 400; k++) begin
            lines   = 8'($urandom);
            clear   = ($urandom_range(0, 3) == 0);
            mask    = 8'($urandom);
            enable  = 8'($urandom);
            min_len = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) mode = 16'($urandom);
            srst_n  = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/irq_catch.md
# irq_catch

Interrupt receiver: the sink end of the team's interrupt-generator lines. Takes `N_IRQ` incoming interrupt lines, each configured per line as level or strobe and as active-high or active-low with the same 2-bit mode encoding the generators use. Qualifies each line with a minimum-active-length glitch filter and latches events into a write-1-to-clear pending register with overrun flags. Presents an aggregated, enable-masked interrupt plus the lowest-index pending ID to the local CPU/register block.

## Interface
- `N_IRQ`, default 8: number of input lines, 1..32.
- `ID_W`, default `$clog2(N_IRQ)` (min 1): width of `irq_id_o`.
- `clk_i`  in  1: sole clock.
- `srst_n_i`  in  1: synchronous, active-low reset.
- `irq_lines_i`  in  N_IRQ: raw incoming interrupt lines.
- `irq_mode_i`  in  2*N_IRQ: per-line mode, bits [2i+1:2i]. 0 = FIXED_P (level, active-high), 1 = STROBE_N (pulse, active-low), 2 = FIXED_N (level, active-low), 3 = STROBE_P (pulse, active-high).
- `min_len_i`  in  16: minimum consecutive active cycles to qualify an event. Value 0 is treated as 1.
- `enable_i`  in  N_IRQ: per-line enable for the aggregate outputs only.
- `clear_i`  in  1: write strobe for W1C.
- `clear_mask_i`  in  N_IRQ: lines to clear when `clear_i` = 1.
- `pending_o`  out  N_IRQ: latched pending bits.
- `overrun_o`  out  N_IRQ: event arrived while already pending.
- `irq_o`  out  1: `|(pending_o & enable_i)`.
- `irq_id_o`  out  ID_W: index of the lowest set bit of `pending_o & enable_i`; 0 when none.

## Operation
- Per line: `act[i]` = line at its active level. P modes are active-high; N modes are active-low.
- Per-line 16-bit saturating counter `cnt[i]` and a `fired[i]` flag:
  - `act` = 0: `cnt` <= 0, `fired` <= 0.
  - `act` = 1: `cnt` <= `cnt` + 1, saturating at 0xFFFF.
  - `qual[i]` = `act` & (`cnt` + 1 >= max(`min_len_i`, 1)).
- Strobe modes: `event[i]` = `qual` & ~`fired`. `fired` <= 1 on `event`. A line held active therefore yields exactly one event per assertion.
- Level modes: `event[i]` = `qual`, every cycle. `pending` cannot be cleared while the line stays qualified.
- Pending update per line, priority order:
  1. `event` wins.
  2. Otherwise `clear_i & clear_mask_i[i]` sets `pending` to 0.
  3. Otherwise hold.
- Overrun:
  - Set when `event` occurs, `pending` = 1, the mode is strobe, and no clear hits that line in the same cycle.
  - Cleared by the same W1C as `pending`, unless set again in that same cycle.
  - Level modes never set overrun.
- Mode change: a registered copy of `irq_mode_i[i]` is kept. Any cycle where it differs from the input, `cnt[i]` and `fired[i]` load 0 and no event is generated. `pending` and `overrun` are untouched.
- A line already active when reset deasserts counts as an event once qualified.
- `irq_o` and `irq_id_o` are combinational from the `pending` register and `enable_i`. No extra latency is added.

## Timing
- Reset (`srst_n_i` = 0 at a rising edge): `pending_o` = 0, `overrun_o` = 0, `irq_o` = 0, `irq_id_o` = 0. All `cnt`, `fired` and mode copies = 0.
- Latency with the macro off:
  - With `min_len_i` ≤ 1, a line first active in the cycle before edge k has `pending_o` high after edge k.
  - With `min_len_i` = L, `pending_o` goes high after the L-th consecutive active edge.
- A pulse shorter than L cycles produces nothing; `cnt` restarts on the next assertion.
- `clear_i` takes effect at the next edge. Clearing a line that is not pending is a no-op.
- `min_len_i` and `enable_i` are sampled every cycle. Changing `min_len_i` mid-count compares the current `cnt` against the new value.

## Configuration
- `IRQ_CATCH_SYNC_EN` defined: each `irq_lines_i` bit passes through a 2-flop synchronizer before `act` is derived.
  - Adds 2 cycles to every latency above.
  - Synchronizer flops reset to the idle level of the line's mode at reset time: 0 for P modes, 1 for N modes.
- Not defined: lines are used directly and are required to be synchronous to `clk_i`.

## Test plan
- STROBE_P, `min_len_i` = 3, line 2 high for 2 cycles -> no pending. Line 2 high for 5 cycles -> `pending_o` = 0x04 after the 3rd edge, exactly one event. `irq_o` = 1 and `irq_id_o` = 2 with `enable_i` = 0xFF.
- STROBE_N on line 0, `min_len_i` = 1, two low pulses without a clear between -> `overrun_o[0]` = 1. `clear_i` with mask 0x01 -> `pending_o[0]` = 0 and `overrun_o[0]` = 0 next cycle.
- FIXED_N on line 5 held low, `clear_i` mask 0x20 each cycle -> `pending_o[5]` stays 1. Release the line, then clear -> 0.
- Simultaneous event and clear on line 1 (STROBE_P, already pending) -> `pending_o[1]` = 1, `overrun_o[1]` = 0.
- Lines 3 and 6 pending, `enable_i` = 0xF7 -> `irq_id_o` = 6. `enable_i` = 0x00 -> `irq_o` = 0 while `pending_o` still = 0x48.
- `srst_n_i` low for one cycle mid-count and while pending -> all outputs 0 next cycle. A line still active re-qualifies after `min_len_i` cycles.
